fpadd_sched: RTL and testbench

FPADD_SCHED -- requirements
Module: fpadd_sched

---
 rtl/fpadd_sched.sv | 107 ++++++++++
 tb/tb_fpadd_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fpadd_sched.sv
// Two-requester round-robin scheduler in front of one shared pipelined fp16 adder.
// Optional FPADD_SCHED_STATS_EN adds per-requester grant counters (issue_cnt0/1).
module fpadd_sched #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req0_op,
  input  logic        req1_op,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_out,
  input  logic        add_ovf,
  input  logic        add_sub,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp0_data,
  output logic [15:0] rsp1_data,
  output logic        rsp0_ovf,
  output logic        rsp0_sub,
  output logic        rsp1_ovf,
  output logic        rsp1_sub,
`ifdef FPADD_SCHED_STATS_EN
  output logic [15:0] issue_cnt0,
  output logic [15:0] issue_cnt1,
`endif
  output logic        busy
);

  logic           r_rr;
  logic [LAT-1:0] r_tag_v;
  logic [LAT-1:0] r_tag_id;
  logic           w_g0, w_g1;

  // rr is the preferred requester; a lone valid requester always wins.
  always_comb begin
    w_g0 = !RST && req0_valid && (!req1_valid || !r_rr);
    w_g1 = !RST && req1_valid && (!req0_valid ||  r_rr);
  end

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  always_comb begin
    add_a = 16'h0000;
    add_b = 16'h0000;
    if (w_g0) begin
      add_a = req0_a;
      add_b = {req0_b[15] ^ req0_op, req0_b[14:0]};
    end else if (w_g1) begin
      add_a = req1_a;
      add_b = {req1_b[15] ^ req1_op, req1_b[14:0]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr     <= 1'b0;
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      if (w_g0)      r_rr <= 1'b1;
      else if (w_g1) r_rr <= 1'b0;
      for (int i = LAT - 1; i > 0; i--) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      r_tag_v[0]  <= w_g0 | w_g1;
      r_tag_id[0] <= w_g1;
    end
  end

  // The tag leaving the shift register lines up with the adder's registered result.
  assign rsp0_valid = r_tag_v[LAT-1] & ~r_tag_id[LAT-1];
  assign rsp1_valid = r_tag_v[LAT-1] &  r_tag_id[LAT-1];
  assign rsp0_data  = rsp0_valid ? add_out : 16'h0000;
  assign rsp1_data  = rsp1_valid ? add_out : 16'h0000;
  assign rsp0_ovf   = rsp0_valid & add_ovf;
  assign rsp0_sub   = rsp0_valid & add_sub;
  assign rsp1_ovf   = rsp1_valid & add_ovf;
  assign rsp1_sub   = rsp1_valid & add_sub;
  assign busy       = |r_tag_v;

`ifdef FPADD_SCHED_STATS_EN
  logic [15:0] r_cnt0, r_cnt1;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt0 <= 16'h0000;
      r_cnt1 <= 16'h0000;
    end else begin
      if (w_g0) r_cnt0 <= r_cnt0 + 16'h0001;
      if (w_g1) r_cnt1 <= r_cnt1 + 16'h0001;
    end
  end
  assign issue_cnt0 = r_cnt0;
  assign issue_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_fpadd_sched.sv
// Directed bench for fpadd_sched with a small table-based fp16 adder model.
module tb_fpadd_sched;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_op = 0, req1_op = 0;
  logic [15:0] add_a, add_b, add_out;
  logic        add_ovf, add_sub;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_data, rsp1_data;
  logic        rsp0_ovf, rsp0_sub, rsp1_ovf, rsp1_sub;
  logic        busy;
`ifdef FPADD_SCHED_STATS_EN
  logic [15:0] issue_cnt0, issue_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  fpadd_sched #(.LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .add_ovf(add_ovf), .add_sub(add_sub),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .rsp0_ovf(rsp0_ovf), .rsp0_sub(rsp0_sub),
    .rsp1_ovf(rsp1_ovf), .rsp1_sub(rsp1_sub),
`ifdef FPADD_SCHED_STATS_EN
    .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Adder stand-in: exact results for the operand pairs used, a^b otherwise.
  function automatic logic [17:0] fadd(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h3C00) return {2'b00, 16'h4000};
    if (a == 16'h4000 && b == 16'hBC00) return {2'b00, 16'h3C00};
    if (a == 16'h7BFF && b == 16'h7BFF) return {2'b10, 16'h7C00};
    return {1'b0, ((a ^ b) & 16'h7C00) == 16'h0000, a ^ b};
  endfunction

  logic [17:0] pipe [LAT];
  always_ff @(posedge CLK) begin
    pipe[0] <= fadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {add_ovf, add_sub, add_out} = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
  endtask

  typedef struct {
    logic v0, v1;
    logic [15:0] a0, b0, a1, b1;
    logic op0, op1;
    logic [1:0] eg;            // {ready1, ready0}
    logic [15:0] ea, eb, ed;
    logic eovf, esub;
  } vec_t;

  vec_t tbl [7];
  logic [1:0] seen;

  initial begin
    // rr starts at 0 after reset and flips to the loser after each grant
    tbl[0] = '{1,0, 16'h3C00,16'h3C00, 16'h0000,16'h0000, 0,0, 2'b01, 16'h3C00,16'h3C00, 16'h4000, 0,0};
    tbl[1] = '{0,1, 16'h0000,16'h0000, 16'h4000,16'h3C00, 0,1, 2'b10, 16'h4000,16'hBC00, 16'h3C00, 0,0};
    tbl[2] = '{1,0, 16'h7BFF,16'h7BFF, 16'h0000,16'h0000, 0,0, 2'b01, 16'h7BFF,16'h7BFF, 16'h7C00, 1,0};
    tbl[3] = '{1,1, 16'h3C00,16'h3C00, 16'h4000,16'h3C00, 0,1, 2'b10, 16'h4000,16'hBC00, 16'h3C00, 0,0};
    tbl[4] = '{1,1, 16'h0001,16'h0000, 16'h4000,16'h3C00, 0,0, 2'b01, 16'h0001,16'h0000, 16'h0001, 0,1};
    tbl[5] = '{0,0, 16'h3C00,16'h3C00, 16'h4000,16'h3C00, 0,0, 2'b00, 16'h0000,16'h0000, 16'h0000, 0,0};
    tbl[6] = '{1,0, 16'h3C00,16'h3C00, 16'h0000,16'h0000, 0,0, 2'b01, 16'h3C00,16'h3C00, 16'h4000, 0,0};

    // Reset state, with both requesters trying
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    idle_inputs();
    @(posedge CLK); #1 RST = 0;

    // Table vectors: one issue, then look for its response LAT cycles later
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_a = tbl[i].a0; req0_b = tbl[i].b0; req0_op = tbl[i].op0;
      req1_a = tbl[i].a1; req1_b = tbl[i].b1; req1_op = tbl[i].op1;
      @(negedge CLK);
      chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, tbl[i].eg);
      chk($sformatf("v%0d_add_a", i), add_a, tbl[i].ea);
      chk($sformatf("v%0d_add_b", i), add_b, tbl[i].eb);
      @(posedge CLK); #1 idle_inputs();
      repeat (LAT - 1) @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("v%0d_rsp_vld", i), {rsp1_valid, rsp0_valid}, tbl[i].eg);
      chk($sformatf("v%0d_rsp", i),
          {rsp1_ovf | rsp0_ovf, rsp1_sub | rsp0_sub, rsp1_data | rsp0_data},
          {tbl[i].eovf, tbl[i].esub, tbl[i].ed});
      @(negedge CLK);
      chk($sformatf("v%0d_pulse_end", i), {rsp1_valid, rsp0_valid}, 2'b00);
    end

    // Both valid for 4 cycles right after reset: 0,1,0,1 and in-order responses
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 RST = 0;
    req0_a = 16'h3C00; req0_b = 16'h3C00;
    req1_a = 16'h4000; req1_b = 16'h3C00;
    for (int i = 0; i < 4 + LAT + 1; i++) begin
      req0_valid = (i < 4); req1_valid = (i < 4); req0_op = 0; req1_op = 1;
      @(negedge CLK);
      if (i < 4)
        chk($sformatf("rr_grant%0d", i), {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
      if (i >= LAT && i - LAT < 4)
        chk($sformatf("rr_rsp%0d", i - LAT), {rsp1_valid, rsp0_valid, rsp1_data | rsp0_data},
            ((i - LAT) % 2) ? {2'b10, 16'h3C00} : {2'b01, 16'h4000});
      else
        chk($sformatf("rr_norsp%0d", i), {rsp1_valid, rsp0_valid}, 2'b00);
      @(posedge CLK); #1;
    end
    idle_inputs();

    // Two issues, reset in the following cycle: nothing must come out afterwards
    @(posedge CLK); #1 req0_valid = 1; req0_a = 16'h3C00; req0_b = 16'h3C00;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("flush_busy_pre", busy, 1'b1);
    @(posedge CLK); #1 idle_inputs(); RST = 1; req0_valid = 1; req1_valid = 1;
    #1;
    chk("flush_busy", busy, 1'b0);
    chk("flush_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("flush_ready", {req1_ready, req0_ready}, 2'b00);
    seen = 2'b00;
    repeat (2) begin
      @(negedge CLK); seen |= {rsp1_valid, rsp0_valid};
    end
    @(posedge CLK); #1 RST = 0; idle_inputs();
    repeat (LAT + 4) begin
      @(negedge CLK); seen |= {rsp1_valid, rsp0_valid};
    end
    chk("flush_no_rsp", seen, 2'b00);
    @(posedge CLK); #1 req0_valid = 1; req1_valid = 1;
    @(negedge CLK);
    chk("flush_rr0", {req1_ready, req0_ready}, 2'b01);
    @(posedge CLK); #1 idle_inputs();
    repeat (LAT + 2) @(posedge CLK);

`ifdef FPADD_SCHED_STATS_EN
    #1 RST = 1;
    @(posedge CLK); #1 RST = 0;
    for (int i = 0; i < 5; i++) begin
      req0_valid = (i < 3); req1_valid = (i >= 3);
      @(posedge CLK); #1;
    end
    idle_inputs();
    @(negedge CLK);
    chk("cnt0", issue_cnt0, 16'd3);
    chk("cnt1", issue_cnt1, 16'd2);
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 RST = 0; req0_valid = 1;
    repeat (65535) @(posedge CLK);
    #1 req0_valid = 0;
    @(negedge CLK);
    chk("cnt0_max", issue_cnt0, 16'hFFFF);
    @(posedge CLK); #1 req0_valid = 1;
    @(posedge CLK); #1 req0_valid = 0;
    @(negedge CLK);
    chk("cnt0_wrap", issue_cnt0, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
